// File: rtl/i2s_pkg.sv
// Shared defaults and the frame-pack helper for the I2S stereo transmitter.
package i2s_pkg;

  localparam int unsigned DEF_SAMPLE_W   = 16;
  localparam int unsigned DEF_SLOT_W     = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  // Widest slot the pack helper supports; callers truncate to 2*SLOT_W.
  localparam int unsigned MAX_SLOT_W  = 32;
  localparam int unsigned MAX_FRAME_W = 2 * MAX_SLOT_W;

  typedef logic [MAX_FRAME_W-1:0] frame_t;

  // Builds {left, pad, right, pad} with each sample MSB-aligned in its slot.
  // Samples arrive zero-extended (right-aligned) in MAX_SLOT_W bits.
  function automatic frame_t pack_frame(input logic [MAX_SLOT_W-1:0] left,
                                        input logic [MAX_SLOT_W-1:0] right,
                                        input int unsigned           sample_w,
                                        input int unsigned           slot_w);
    logic [MAX_SLOT_W-1:0] l_slot;
    logic [MAX_SLOT_W-1:0] r_slot;
    frame_t                f;
    l_slot = left << (slot_w - sample_w);
    r_slot = right << (slot_w - sample_w);
    f      = (MAX_FRAME_W'(l_slot) << slot_w) | MAX_FRAME_W'(r_slot);
    return f;
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous show-ahead FIFO buffering stereo frames for the I2S transmitter.
module i2s_tx_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * DEF_SAMPLE_W,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata_c,
  output logic                       o_empty_c,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_level;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + PW'(1);
        2'b01:   r_level <= r_level - PW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata_c = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty_c = w_empty;
  assign o_level   = r_level;

endmodule

// File: rtl/i2s_tx_stereo.sv
// I2S stereo transmitter: frame FIFO, bclk divider, slot sequencer and MSB-first shifter.
// Optional low-water irq is enabled by defining I2S_TX_LOWWATER_IRQ_EN.
module i2s_tx_stereo
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
  parameter int unsigned SLOT_W     = DEF_SLOT_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned BCLK_DIV   = 8,
  parameter int unsigned LOW_WATER  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SAMPLE_W-1:0]           in_left,
  input  logic [SAMPLE_W-1:0]           in_right,
  output logic                          bclk,
  output logic                          lr_clk,
  output logic                          serial,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          underrun,
  output logic                          irq
);

  localparam int unsigned DIV_W   = $clog2(BCLK_DIV + 1);
  localparam int unsigned FRAME_W = 2 * SLOT_W;
  localparam int unsigned IDX_W   = $clog2(FRAME_W);
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DATA_W  = 2 * SAMPLE_W;

  logic [DIV_W-1:0]   r_div_cnt;
  logic               r_bclk;
  logic               r_lr;
  logic               r_serial;
  logic               r_underrun;
  logic               r_armed;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [FRAME_W-1:0] r_shreg;

  logic               w_div_tc;
  logic               w_fall;
  logic               w_frame_start;
  logic [DATA_W-1:0]  w_rdata;
  logic               w_empty;
  logic [LVL_W-1:0]   w_level;
  logic [FRAME_W-1:0] w_load;

  i2s_tx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (in_valid && in_ready),
    .i_wdata   ({in_left, in_right}),
    .i_pop     (w_frame_start),
    .o_rdata_c (w_rdata),
    .o_empty_c (w_empty),
    .o_level   (w_level)
  );

  assign in_ready = (w_level < LVL_W'(FIFO_DEPTH));

  // r_armed makes the first fall event after reset open a fresh left slot.
  assign w_div_tc      = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
  assign w_fall        = w_div_tc && r_bclk;
  assign w_frame_start = w_fall && (r_armed || (r_bit_idx == IDX_W'(FRAME_W - 1)));

  assign w_load = w_empty ? '0 :
                  FRAME_W'(pack_frame(MAX_SLOT_W'(w_rdata[DATA_W-1:SAMPLE_W]),
                                      MAX_SLOT_W'(w_rdata[SAMPLE_W-1:0]),
                                      SAMPLE_W, SLOT_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_bclk     <= 1'b0;
      r_lr       <= 1'b1;
      r_serial   <= 1'b0;
      r_underrun <= 1'b0;
      r_armed    <= 1'b1;
      r_bit_idx  <= '0;
      r_shreg    <= '0;
    end else begin
      r_div_cnt  <= w_div_tc ? '0 : r_div_cnt + DIV_W'(1);
      r_underrun <= w_frame_start && w_empty;
      if (w_div_tc) r_bclk <= ~r_bclk;
      // Serial takes the current MSB, so the loaded left MSB appears one bclk later.
      if (w_fall) begin
        r_armed  <= 1'b0;
        r_serial <= r_shreg[FRAME_W-1];
        if (w_frame_start) begin
          r_bit_idx <= '0;
          r_lr      <= 1'b0;
          r_shreg   <= w_load;
        end else begin
          r_bit_idx <= r_bit_idx + IDX_W'(1);
          r_shreg   <= {r_shreg[FRAME_W-2:0], 1'b0};
          if (r_bit_idx == IDX_W'(SLOT_W - 1)) r_lr <= 1'b1;
        end
      end
    end
  end

  assign bclk     = r_bclk;
  assign lr_clk   = r_lr;
  assign serial   = r_serial;
  assign underrun = r_underrun;
  assign level    = w_level;

`ifdef I2S_TX_LOWWATER_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= (w_level <= LVL_W'(LOW_WATER));
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Scoreboard bench for i2s_tx_stereo: expected frames are queued at stimulus time, a monitor checks each serial frame.
module tb_i2s_tx_stereo;

`ifdef I2S_TX_LOWWATER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  localparam int LW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: default parameters
  logic        rst0 = 1'b1, in_valid0 = 1'b0;
  logic [15:0] in_left0 = '0, in_right0 = '0;
  logic        in_ready0, bclk0, lr0, serial0, underrun0, irq0;
  logic [3:0]  level0;

  // dut1: 12-bit samples in 16-bit slots, fast bclk
  logic        rst1 = 1'b1, in_valid1 = 1'b0;
  logic [11:0] in_left1 = '0, in_right1 = '0;
  logic        in_ready1, bclk1, lr1, serial1, underrun1, irq1;
  logic [2:0]  level1;

  i2s_tx_stereo u_dut0 (
    .clk(clk), .rst(rst0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_left(in_left0), .in_right(in_right0), .bclk(bclk0), .lr_clk(lr0),
    .serial(serial0), .level(level0), .underrun(underrun0), .irq(irq0)
  );

  i2s_tx_stereo #(.SAMPLE_W(12), .SLOT_W(16), .FIFO_DEPTH(4), .BCLK_DIV(2)) u_dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_left(in_left1), .in_right(in_right1), .bclk(bclk1), .lr_clk(lr1),
    .serial(serial1), .level(level1), .underrun(underrun1), .irq(irq1)
  );

  typedef struct {
    logic [31:0] bits;
    int          und;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor state per DUT
  bit          coll[2];
  logic        pb[2];
  logic        pl[2];
  logic [31:0] sbits[2];
  logic [31:0] slrs[2];
  int          snb[2];
  int          sund[2];

  task automatic mon_step(input int id, input logic r, input logic b, input logic l,
                          input logic s, input logic u);
    exp_t e;
    bit   have;
    if (r) begin
      coll[id] = 1'b0;
      pb[id]   = 1'b0;
      pl[id]   = 1'b1;
      return;
    end
    if (pb[id] && !b) begin
      if (coll[id]) begin
        sbits[id] = {sbits[id][30:0], s};
        slrs[id]  = {slrs[id][30:0], l};
        snb[id]++;
      end
      if (pl[id] && !l) begin
        if (coll[id]) begin
          have = 1'b0;
          if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          else if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          if (!have) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut%0d_unexpected_frame actual=%0h required=none", id, sbits[id]);
          end else begin
            chk($sformatf("dut%0d_frame_bits", id), 64'(sbits[id]), 64'(e.bits));
            chk($sformatf("dut%0d_frame_lr", id), 64'(slrs[id]), 64'h0001_FFFE);
            chk($sformatf("dut%0d_frame_len", id), 64'(snb[id]), 64'd32);
            chk($sformatf("dut%0d_underrun_pulses", id), 64'(sund[id]), 64'(e.und));
          end
        end
        coll[id]  = 1'b1;
        sbits[id] = '0;
        slrs[id]  = '0;
        snb[id]   = 0;
        sund[id]  = 0;
      end
    end
    if (coll[id] && u) sund[id]++;
    pb[id] = b;
    pl[id] = l;
  endtask

  always @(negedge clk) begin
    mon_step(0, rst0, bclk0, lr0, serial0, underrun0);
    mon_step(1, rst1, bclk1, lr1, serial1, underrun1);
  end

  function automatic exp_t mk(input logic [31:0] bits, input int und);
    exp_t e;
    e.bits = bits;
    e.und  = und;
    return e;
  endfunction

  // Returns at the first negedge after lr_clk of dut0 falls.
  task automatic wait_lr_fall0(input string tag);
    logic p;
    bit   ok;
    p  = lr0;
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (p && !lr0) begin
        ok = 1'b1;
        break;
      end
      p = lr0;
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_bclk"}, 64'(bclk0), 64'd0);
    chk({tag, "_lr"}, 64'(lr0), 64'd1);
    chk({tag, "_serial"}, 64'(serial0), 64'd0);
    chk({tag, "_level"}, 64'(level0), 64'd0);
    chk({tag, "_underrun"}, 64'(underrun0), 64'd0);
    chk({tag, "_irq"}, 64'(irq0), 64'd0);
  endtask

  task automatic first_fall_latency0(input string tag);
    int n;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (!lr0) begin
        n = i;
        break;
      end
    end
    chk(tag, 64'(n), 64'd16);
  endtask

  initial begin
    logic [15:0] fl;
    logic [15:0] fr;
    bit          done;

    // dut1: 12-bit left sample of all ones -> 12 ones then 4 zero pad bits
    repeat (3) @(negedge clk);
    q1.push_back(mk(32'hFFF0_0010, 0));
    q1.push_back(mk(32'h0000_0000, 1));
    rst1      = 1'b0;
    in_valid1 = 1'b1;
    in_left1  = 12'hFFF;
    in_right1 = 12'h001;
    @(negedge clk);
    in_valid1 = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (q1.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("dut1_frames_seen", 64'(done), 64'd1);
    rst1 = 1'b1;

    // dut0 reset values
    @(negedge clk);
    chk_reset0("reset");
    chk("reset_in_ready", 64'(in_ready0), 64'd1);

    // No data: two underrun frames of zeros
    q0.push_back(mk(32'h0, 1));
    q0.push_back(mk(32'h0, 1));
    rst0 = 1'b0;
    first_fall_latency0("first_fall_latency");
    wait_lr_fall0("wait_s2");

    // Single frame L=8001 R=7FFE
    in_valid0 = 1'b1;
    in_left0  = 16'h8001;
    in_right0 = 16'h7FFE;
    q0.push_back(mk(32'h8001_7FFE, 0));
    @(negedge clk);
    in_valid0 = 1'b0;
    chk("level_after_push", 64'(level0), 64'd1);
    wait_lr_fall0("wait_s3");
    chk("level_after_pop", 64'(level0), 64'd0);

    // Fill: 8 frames accepted, 9th held off until a pop frees a slot
    for (int i = 0; i < 9; i++) begin
      fl = 16'h05A3 | (16'(i + 1) << 12);
      fr = 16'hC3C0 | 16'(i);
      in_valid0 = 1'b1;
      in_left0  = fl;
      in_right0 = fr;
      q0.push_back(mk({fl, fr}, 0));
      if (i < 8) @(negedge clk);
    end
    chk("full_in_ready", 64'(in_ready0), 64'd0);
    chk("full_level", 64'(level0), 64'd8);
    @(negedge clk);
    chk("full_hold_level", 64'(level0), 64'd8);
    wait_lr_fall0("wait_s4");
    chk("pop_at_full_refuses_push", 64'(level0), 64'd7);
    @(negedge clk);
    in_valid0 = 1'b0;
    chk("ninth_accepted", 64'(level0), 64'd8);

    // Drain: level steps down once per frame; irq tracks the low-water mark
    for (int k = 7; k >= 0; k--) begin
      wait_lr_fall0($sformatf("wait_drain%0d", k));
      chk($sformatf("drain_level%0d", k), 64'(level0), 64'(k));
      chk($sformatf("irq_pre%0d", k), 64'(irq0), 64'(IRQ_ON && (k + 1 <= LW)));
      @(negedge clk);
      chk($sformatf("irq_post%0d", k), 64'(irq0), 64'(IRQ_ON && (k <= LW)));
    end
    q0.push_back(mk(32'h0, 1));
    wait_lr_fall0("wait_s13");
    wait_lr_fall0("wait_s14");

    // Mid-frame reset discards a buffered frame and the partial frame
    in_valid0 = 1'b1;
    in_left0  = 16'h1234;
    in_right0 = 16'h5678;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (200) @(negedge clk);
    chk("sb_drained", 64'(q0.size()), 64'd0);
    chk("pre_reset_level", 64'(level0), 64'd1);
    rst0 = 1'b1;
    #1;
    chk_reset0("midreset");
    repeat (3) @(negedge clk);
    q0.push_back(mk(32'h0, 1));
    rst0 = 1'b0;
    first_fall_latency0("restart_latency");
    wait_lr_fall0("wait_restart_s2");
    @(negedge clk);
    chk("post_reset_frame", 64'(q0.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx_stereo.md
I2S_TX_STEREO -- requirements
Module: i2s_tx_stereo

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16: significant bits per channel sample.
REQ-002 SHALL have parameter SLOT_W, default 16: bclk periods per channel slot; SAMPLE_W <= SLOT_W is required.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: stereo frames buffered; power of two, >= 2.
REQ-004 SHALL have parameter BCLK_DIV, default 8: clk cycles per bclk half-period; >= 1.
REQ-005 SHALL have parameter LOW_WATER, default 2: FIFO level at or below which irq asserts.
REQ-006 SHALL have port clk, input, 1: single system clock; all logic on posedge clk.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1: a stereo frame is offered.
REQ-009 SHALL have port in_ready, output, 1: the FIFO accepts a frame this cycle.
REQ-010 SHALL have port in_left, input, SAMPLE_W: left sample, two's complement.
REQ-011 SHALL have port in_right, input, SAMPLE_W: right sample, two's complement.
REQ-012 SHALL have port bclk, output, 1: I2S bit clock.
REQ-013 SHALL have port lr_clk, output, 1: word select; 0 = left, 1 = right.
REQ-014 SHALL have port serial, output, 1: I2S data, MSB first.
REQ-015 SHALL have port level, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
REQ-016 SHALL have port underrun, output, 1: one-clk pulse when a frame starts with the FIFO empty.
REQ-017 SHALL have port irq, output, 1: low-water request to the host.

Function
REQ-018 SHALL drive in_ready = (level < FIFO_DEPTH) combinationally; a push occurs on a clk edge with in_valid && in_ready.
REQ-019 SHALL count clk cycles 0..BCLK_DIV-1 and toggle bclk on the terminal count, giving a bclk period of 2*BCLK_DIV clk cycles.
REQ-020 SHALL treat the clk edge on which bclk goes 1->0 as the "fall event"; serial and lr_clk change only on fall events.
REQ-021 SHALL keep a bit index 0..2*SLOT_W-1, incremented at each fall event and wrapping to 0.
REQ-022 SHALL drive lr_clk 1->0 at the fall event where the index wraps to 0, and 0->1 at the fall event where the index reaches SLOT_W.
REQ-023 SHALL pop one frame at the lr_clk 1->0 fall event and load a 2*SLOT_W shift register as {left, zero pad, right, zero pad}, with the samples MSB-aligned.
REQ-024 SHALL present the left MSB on the fall event after the load (one-bclk I2S delay), then shift one bit per fall event.
REQ-025 SHALL, on a pop with level = 0, load all zeros, pulse underrun for exactly one clk, and leave level at 0.
REQ-026 SHALL, on a simultaneous push and pop with 0 < level < FIFO_DEPTH, keep level unchanged and pass the data through the FIFO in order.
REQ-027 SHALL, on a simultaneous push and pop at level = 0, flag underrun and store the pushed frame (level becomes 1).
REQ-028 SHALL, at level = FIFO_DEPTH, refuse the push even when a pop occurs on the same edge.
REQ-029 SHALL use wrapping FIFO pointers of $clog2(FIFO_DEPTH)+1 bits, so full and empty are distinct.

Reset
REQ-030 SHALL, while rst is high, force bclk=0, lr_clk=1, serial=0, level=0, underrun=0, irq=0, all counters=0 and the shift register=0.
REQ-031 SHALL, on a mid-frame reset, discard FIFO contents and the partial frame; the first fall event after release begins a new left slot.

Configuration
REQ-032 SHALL, with I2S_TX_LOWWATER_IRQ_EN defined, register irq = (level <= LOW_WATER), updated every clk.
REQ-033 SHALL, without I2S_TX_LOWWATER_IRQ_EN, tie irq to 0, omit the comparator, and ignore LOW_WATER.

Structure
REQ-034 SHALL place the default SLOT_W, SAMPLE_W and FIFO_DEPTH localparams and the frame-pack helper function in shared package i2s_pkg.
REQ-035 SHALL implement the buffer as sub-module i2s_tx_fifo (synchronous FIFO, width 2*SAMPLE_W, depth FIFO_DEPTH).

Verification
REQ-036 SHALL cover: defaults, push L=16'h8001, R=16'h7FFE -> serial shows 1000...0001 then 0111...1110, each MSB one bclk after the lr_clk edge.
REQ-037 SHALL cover: no pushes after reset -> one underrun pulse per frame and serial constantly 0.
REQ-038 SHALL cover: push 9 frames back-to-back with FIFO_DEPTH=8 -> in_ready low after the 8th frame and level=8.
REQ-039 SHALL cover: SAMPLE_W=12, SLOT_W=16, L=12'hFFF -> 12 ones then 4 zeros in the left slot.
REQ-040 SHALL cover: macro defined, level drains from 4 to 2 -> irq rises the clk after level=2; assert rst mid-frame -> all outputs return to their reset values immediately.
